// File: rtl/ifu_fetch.sv
// ifu_fetch: owns the PC, fetches words over imem req/gnt/rvalid and buffers them for decode.
// Defining IFU_MISALIGN_TRAP_EN makes a misaligned redirect raise fetch_fault and halt fetch.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic        fetch_fault
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   logic          run_q;
   logic [31:0]   pc_q;
   logic [CW-1:0] count_q, outstanding_q, discard_q;
   logic [CW-1:0] count_nxt, outstanding_nxt, discard_nxt;
   logic [PW-1:0] rd_ptr_q, wr_ptr_q, pcq_rd_q, pcq_wr_q;
   logic [31:0]   fifo_instr [FIFO_DEPTH];
   logic [31:0]   fifo_pc    [FIFO_DEPTH];
   logic [31:0]   pcq_mem    [FIFO_DEPTH];
   logic          fault_q;
   logic          grant, pop, rsp_keep;
   logic [CW:0]   occupancy;

`ifdef IFU_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fault_q <= 1'b0;
      else if (redirect_valid)
         fault_q <= (redirect_pc[1:0] != 2'b00);
   end
`else
   logic unused_redirect_lsb;
   assign fault_q             = 1'b0;
   assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

   // Buffered plus in-flight words never exceed the buffer, so a response always has a slot.
   assign occupancy   = {1'b0, count_q} + {1'b0, outstanding_q};
   assign imem_req    = run_q && !redirect_valid && !fault_q && (occupancy < DEPTH_C);
   assign imem_addr   = pc_q;
   assign grant       = imem_req && imem_gnt;
   assign id_valid    = (count_q != '0);
   assign pop         = id_valid && id_ready;
   assign rsp_keep    = imem_rvalid && (discard_q == '0) && !redirect_valid;
   assign id_instr    = id_valid ? fifo_instr[rd_ptr_q] : NOP;
   assign id_pc       = id_valid ? fifo_pc[rd_ptr_q] : 32'h0;
   assign fetch_fault = fault_q;

   always_comb begin
      outstanding_nxt = outstanding_q;
      if (grant && !imem_rvalid)
         outstanding_nxt = outstanding_q + CW'(1);
      else if (!grant && imem_rvalid)
         outstanding_nxt = outstanding_q - CW'(1);

      // Every request still in flight after a redirect belongs to the old path.
      discard_nxt = discard_q;
      if (redirect_valid)
         discard_nxt = outstanding_nxt;
      else if (imem_rvalid && (discard_q != '0))
         discard_nxt = discard_q - CW'(1);

      count_nxt = count_q;
      if (redirect_valid)
         count_nxt = '0;
      else if (rsp_keep && !pop)
         count_nxt = count_q + CW'(1);
      else if (!rsp_keep && pop)
         count_nxt = count_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q         <= 1'b0;
         pc_q          <= RESET_PC;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         pcq_rd_q      <= '0;
         pcq_wr_q      <= '0;
      end else begin
         run_q         <= 1'b1;
         count_q       <= count_nxt;
         outstanding_q <= outstanding_nxt;
         discard_q     <= discard_nxt;
         // The request-PC queue follows every response, including discarded ones.
         if (grant)
            pcq_wr_q <= pcq_wr_q + PW'(1);
         if (imem_rvalid)
            pcq_rd_q <= pcq_rd_q + PW'(1);
         if (redirect_valid) begin
            pc_q     <= {redirect_pc[31:2], 2'b00};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (grant)
               pc_q <= pc_q + 32'd4;
            if (rsp_keep)
               wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
               rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (grant)
         pcq_mem[pcq_wr_q] <= pc_q;
      if (rsp_keep) begin
         fifo_instr[wr_ptr_q] <= imem_rdata;
         fifo_pc[wr_ptr_q]    <= pcq_mem[pcq_rd_q];
      end
   end

endmodule
